// File: rtl/csd2bin_seq_pkg.sv
// Shared CSD digit codes, digit record and converter FSM encodings.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package csd_pkg;

  localparam logic [1:0] CSD_POS  = 2'b10;
  localparam logic [1:0] CSD_NEG  = 2'b01;
  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_INV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One CSD digit as carried on the bus: value is p - n.
  typedef struct packed {
    logic p;
    logic n;
  } csd_digit_t;

  function automatic logic digit_nonzero(input csd_digit_t d);
    return (d == CSD_POS) || (d == CSD_NEG);
  endfunction

endpackage

// File: rtl/csd2bin_seq_if.sv
// Word-in / result-out handshake bundle for the CSD to binary converter.
// Latency: none (wiring only).
// Backpressure: valid/ready on both sides.
interface csd2bin_seq_if #(
  parameter int W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic             neg;
  logic [2*W-1:0]   a;
  logic             out_valid;
  logic             out_ready;
  logic [W:0]       y;
  logic             err;

  modport master (
    output in_valid, neg, a, out_ready,
    input  in_ready, out_valid, y, err
  );

  modport slave (
    input  in_valid, neg, a, out_ready,
    output in_ready, out_valid, y, err
  );

endinterface

// File: rtl/csd2bin_seq_digit_sub.sv
// Single CSD digit subtractor: d = p - n - bin, emits d mod 2 and borrow (d < 0).
// Latency: combinational.
// Backpressure: none.
module csd_digit_sub (
  input  logic p,
  input  logic n,
  input  logic bin,
  output logic y_bit,
  output logic bout
);

  assign y_bit = p ^ n ^ bin;
  // d ranges -2..1; it goes negative unless p covers every subtracted unit.
  assign bout  = (~p & (n | bin)) | (n & bin);

endmodule

// File: rtl/csd2bin_seq.sv
// CSD to two's complement converter, one digit per cycle LSD first; optional CSD2BIN_CHECK_EN canonicity flag.
// Latency: out_valid rises W edges after acceptance; new word every W+2 cycles minimum.
// Backpressure: result and err held in DONE until out_ready; in_ready low outside IDLE.
module csd2bin_seq
  import csd_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  csd2bin_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(W);

  state_t                 state_q, state_d;
  csd_digit_t [W-1:0]     a_q;
  logic                   neg_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   borrow_q;
  logic [W-1:0]           acc_q;
  logic [W:0]             y_q;

  logic                   accept;
  logic                   step;
  logic                   last;
  csd_digit_t             cur;
  logic                   y_bit;
  logic                   bout;
  logic [W:0]             res;
  logic [W:0]             res_fin;

  assign cur  = a_q[cnt_q];
  assign last = (cnt_q == CNT_W'(W - 1));

  csd_digit_sub u_sub (
    .p     (cur.p),
    .n     (cur.n),
    .bin   (borrow_q),
    .y_bit (y_bit),
    .bout  (bout)
  );

  // Final digit folds in directly so the result lands in y on the DONE entry edge.
  always_comb begin
    res     = {bout, y_bit, acc_q[W-2:0]};
    res_fin = neg_q ? (~res + (W+1)'(1)) : res;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    step          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        step = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      acc_q    <= '0;
      y_q      <= '0;
    end else begin
      if (accept) begin
        a_q      <= bus.a;
        neg_q    <= bus.neg;
        cnt_q    <= '0;
        borrow_q <= 1'b0;
        acc_q    <= '0;
      end
      if (step) begin
        acc_q[cnt_q] <= y_bit;
        borrow_q     <= bout;
        if (last) y_q   <= res_fin;
        else      cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.y = y_q;

`ifdef CSD2BIN_CHECK_EN
  logic err_acc_q;
  logic prev_nz_q;
  logic err_q;
  logic err_now;

  assign err_now = err_acc_q | (cur == CSD_INV) | (prev_nz_q & digit_nonzero(cur));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc_q <= 1'b0;
      prev_nz_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        err_acc_q <= 1'b0;
        prev_nz_q <= 1'b0;
      end
      if (step) begin
        err_acc_q <= err_now;
        prev_nz_q <= digit_nonzero(cur);
        if (last) err_q <= err_now;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
